// File: rtl/expmul_stream.sv
// rtl/expmul_stream.sv - exp-multiply rescale stage streaming v*2^e_v and o*2^e_o in LANES-wide beats
//
// Accepts one score-update transaction (m, m_prev, s, o*, v*), derives the
// base-2 exponents e_v ~ (s-m)*log2e and e_o ~ (m_prev-m)*log2e once, then
// streams the rescaled vectors LANES elements per beat.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   vld_in / rdy_out      upstream transaction handshake
//   m_in, m_prev_in, s_in signed Q4.4 scalars
//   o_star_prev_in        previous output accumulator, DIM x DW signed Q9.17
//   v_star_in             value vector, DIM x DW signed Q9.17
//   vld_out / rdy_in      downstream beat handshake
//   exp_v_out, exp_o_out  rescaled v / o lanes of the current beat
//   beat_idx_out          index of the current beat
//   last_out              current beat is the final beat of the vector
//   sat_out               at least one lane of the current beat saturated
module expmul_stream #(
    parameter int DIM   = 65,
    parameter int LANES = 8,
    parameter int DW    = 27,
    parameter int SW    = 9,
    localparam int NB   = (DIM + LANES - 1) / LANES,
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vld_in,
    output logic                rdy_out,
    input  logic [SW-1:0]       m_in,
    input  logic [SW-1:0]       m_prev_in,
    input  logic [SW-1:0]       s_in,
    input  logic [DIM*DW-1:0]   o_star_prev_in,
    input  logic [DIM*DW-1:0]   v_star_in,
    output logic                vld_out,
    input  logic                rdy_in,
    output logic [LANES*DW-1:0] exp_v_out,
    output logic [LANES*DW-1:0] exp_o_out,
    output logic [BW-1:0]       beat_idx_out,
    output logic                last_out,
    output logic                sat_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    // Element storage is padded to a whole number of beats; the padding
    // entries stay zero, so tail lanes output 0 and never saturate.
    localparam int NE = NB * LANES;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int TW = SW + 6;             // holds 23*d for a SW+1 bit d
    localparam int EW = SW - 1;             // signed exponent width
    localparam int HR = 2 ** (EW - 1);      // headroom for the largest left shift

    logic [1:0]          state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic signed [EW-1:0] e_v_q, e_v_d, e_o_q, e_o_d;
    logic [SW-1:0]       m_q, m_d, mp_q, mp_d, s_q, s_d;
    logic [DW-1:0]       v_q [NE];
    logic [DW-1:0]       v_d [NE];
    logic [DW-1:0]       o_q [NE];
    logic [DW-1:0]       o_d [NE];

    logic                in_stream, is_last, accept, sat_any;
    logic [LANES*DW-1:0] ev_lanes, eo_lanes;
    logic [IW-1:0]       idx;
    logic [DW:0]         rv, ro;

    // Round-half-away-from-zero of (a-b)*23/256: Q4.4 difference times
    // 1.4375 (log2e approximation) lands in Q.8, evaluated exactly.
    function automatic logic signed [EW-1:0] exp2_of(input logic [SW-1:0] a,
                                                     input logic [SW-1:0] b);
        logic signed [SW:0]   d;
        logic signed [TW-1:0] t;
        logic [TW-1:0]        mag;
        logic [TW-1:0]        r;
        d   = $signed({a[SW-1], a}) - $signed({b[SW-1], b});
        t   = $signed({{(TW-SW-1){d[SW]}}, d}) * $signed(TW'(23));
        mag = t[TW-1] ? TW'(-t) : TW'(t);
        r   = (mag + TW'(128)) >> 8;
        return t[TW-1] ? -r[EW-1:0] : r[EW-1:0];
    endfunction

    // Returns {saturated, x * 2^e}; right shifts floor and clamp to DW-1.
    function automatic logic [DW:0] scale(input logic [DW-1:0] x,
                                          input logic signed [EW-1:0] e);
        logic signed [DW+HR-1:0] wide;
        logic [EW-1:0]           amt;
        logic [DW-1:0]           val;
        logic                    sat;
        val  = x;
        sat  = 1'b0;
        wide = '0;
        amt  = '0;
        if (e < 0) begin
            amt = -e;
            if (amt > EW'(DW - 1)) begin
                amt = EW'(DW - 1);
            end
            val = $signed(x) >>> amt;
        end else if (e > 0) begin
            wide = $signed({{HR{x[DW-1]}}, x}) <<< e;
            // Result fits only if everything above the DW-bit sign agrees.
            if ((&wide[DW+HR-1:DW-1]) || !(|wide[DW+HR-1:DW-1])) begin
                val = wide[DW-1:0];
            end else begin
                sat = 1'b1;
                val = x[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end
        end
        return {sat, val};
    endfunction

    assign in_stream = (state_q == S_STREAM);
    assign is_last   = (beat_q == BW'(NB - 1));
    assign rdy_out   = !rst && ((state_q == S_IDLE) || (in_stream && is_last && rdy_in));
    assign accept    = vld_in && rdy_out;

    always_comb begin
        ev_lanes = '0;
        eo_lanes = '0;
        sat_any  = 1'b0;
        idx      = '0;
        rv       = '0;
        ro       = '0;
        for (int j = 0; j < LANES; j++) begin
            idx = IW'(beat_q) * IW'(LANES) + IW'(j);
            rv  = scale(v_q[idx], e_v_q);
            ro  = scale(o_q[idx], e_o_q);
            ev_lanes[j*DW +: DW] = rv[DW-1:0];
            eo_lanes[j*DW +: DW] = ro[DW-1:0];
            sat_any = sat_any | rv[DW] | ro[DW];
        end
    end

    assign vld_out      = in_stream;
    assign exp_v_out    = in_stream ? ev_lanes : '0;
    assign exp_o_out    = in_stream ? eo_lanes : '0;
    assign beat_idx_out = in_stream ? beat_q : '0;
    assign last_out     = in_stream && is_last;
    assign sat_out      = in_stream && sat_any;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        e_v_d   = e_v_q;
        e_o_d   = e_o_q;
        m_d     = m_q;
        mp_d    = mp_q;
        s_d     = s_q;
        v_d     = v_q;
        o_d     = o_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                e_v_d   = exp2_of(s_q, m_q);
                e_o_d   = exp2_of(mp_q, m_q);
                beat_d  = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (rdy_in) begin
                    if (is_last) begin
                        // A transaction accepted on the final handshake skips IDLE.
                        state_d = accept ? S_CALC : S_IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            m_d  = m_in;
            mp_d = m_prev_in;
            s_d  = s_in;
            for (int i = 0; i < DIM; i++) begin
                v_d[i] = v_star_in[i*DW +: DW];
                o_d[i] = o_star_prev_in[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            e_v_q   <= '0;
            e_o_q   <= '0;
            m_q     <= '0;
            mp_q    <= '0;
            s_q     <= '0;
            for (int i = 0; i < NE; i++) begin
                v_q[i] <= '0;
                o_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            e_v_q   <= e_v_d;
            e_o_q   <= e_o_d;
            m_q     <= m_d;
            mp_q    <= mp_d;
            s_q     <= s_d;
            v_q     <= v_d;
            o_q     <= o_d;
        end
    end

endmodule

// File: tb/tb_expmul_stream.sv
// tb/tb_expmul_stream.sv - self-checking bench for expmul_stream
module tb_expmul_stream;
    localparam int DIM   = 65;
    localparam int LANES = 8;
    localparam int DW    = 27;
    localparam int SW    = 9;
    localparam int NB    = (DIM + LANES - 1) / LANES;
    localparam int BW    = $clog2(NB);

    logic                clk = 1'b0;
    logic                rst, vld_in, rdy_out, vld_out, rdy_in, last_out, sat_out;
    logic [SW-1:0]       m_in, m_prev_in, s_in;
    logic [DIM*DW-1:0]   o_star_prev_in, v_star_in;
    logic [LANES*DW-1:0] exp_v_out, exp_o_out;
    logic [BW-1:0]       beat_idx_out;

    int errors = 0;
    int checks = 0;

    int     nxt_m, nxt_mp, nxt_s, cur_m, cur_mp, cur_s, cur_ev, cur_eo;
    longint nxt_v [DIM];
    longint nxt_o [DIM];
    longint cur_v [DIM];
    longint cur_o [DIM];
    logic [DW-1:0] cap_v1, cap_v2, cap_o1;
    logic          cap_sat0, cap_sat1;
    int            beats_seen, last_beat_seen;

    always #5 clk = ~clk;

    expmul_stream #(.DIM(DIM), .LANES(LANES), .DW(DW), .SW(SW)) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
        .m_in(m_in), .m_prev_in(m_prev_in), .s_in(s_in),
        .o_star_prev_in(o_star_prev_in), .v_star_in(v_star_in),
        .vld_out(vld_out), .rdy_in(rdy_in),
        .exp_v_out(exp_v_out), .exp_o_out(exp_o_out),
        .beat_idx_out(beat_idx_out), .last_out(last_out), .sat_out(sat_out)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Exponent: (a-b)/16 * 1.4375, rounded half away from zero.
    function automatic int e_ref(int a, int b);
        real x;
        x = real'(a - b) * 23.0 / 256.0;
        if (x < 0.0) return -$rtoi($floor(-x + 0.5));
        return $rtoi($floor(x + 0.5));
    endfunction

    // Real-valued x * 2^e, floored, shift depth limited to DW-1, clamped to DW bits.
    function automatic longint scale_ref(longint x, int e, output bit sat);
        real p, r, hi, lo;
        int  k;
        k  = (e < -(DW - 1)) ? -(DW - 1) : e;
        p  = 1.0;
        for (int n = 0; n < k; n++) p = p * 2.0;
        for (int n = 0; n < -k; n++) p = p / 2.0;
        hi = real'((longint'(1) << (DW - 1)) - 1);
        lo = -real'(longint'(1) << (DW - 1));
        r  = $floor(real'(x) * p);
        sat = 1'b0;
        if (r > hi) begin r = hi; sat = 1'b1; end
        else if (r < lo) begin r = lo; sat = 1'b1; end
        return longint'($rtoi(r));
    endfunction

    function automatic longint rand_elem();
        if ($urandom_range(0, 3) == 0) return longint'($urandom_range(0, 200)) - 100;
        return longint'($urandom_range(0, (1 << DW) - 1)) - (longint'(1) << (DW - 1));
    endfunction

    task automatic chk(input string tag, input logic [LANES*DW-1:0] obs,
                       input logic [LANES*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_nxt();
        nxt_m = 0; nxt_mp = 0; nxt_s = 0;
        for (int i = 0; i < DIM; i++) begin nxt_v[i] = 0; nxt_o[i] = 0; end
    endtask

    task automatic gen_rand();
        int d;
        nxt_m = int'($urandom_range(0, 511)) - 256;
        d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 511));
        nxt_s = (nxt_m - d < -256) ? -256 : nxt_m - d;
        d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 511));
        nxt_mp = (nxt_m - d < -256) ? -256 : nxt_m - d;
        for (int i = 0; i < DIM; i++) begin nxt_v[i] = rand_elem(); nxt_o[i] = rand_elem(); end
    endtask

    task automatic drive_nxt();
        logic [63:0] t;
        m_in      = nxt_m[SW-1:0];
        m_prev_in = nxt_mp[SW-1:0];
        s_in      = nxt_s[SW-1:0];
        for (int i = 0; i < DIM; i++) begin
            t = nxt_v[i]; v_star_in[i*DW +: DW] = t[DW-1:0];
            t = nxt_o[i]; o_star_prev_in[i*DW +: DW] = t[DW-1:0];
        end
        vld_in = 1'b1;
    endtask

    task automatic take_nxt();
        cur_m = nxt_m; cur_mp = nxt_mp; cur_s = nxt_s;
        for (int i = 0; i < DIM; i++) begin cur_v[i] = nxt_v[i]; cur_o[i] = nxt_o[i]; end
        cur_ev = e_ref(cur_s, cur_m);
        cur_eo = e_ref(cur_mp, cur_m);
    endtask

    // Garbage on the inputs after acceptance must not reach the transaction.
    task automatic scramble();
        vld_in    = 1'b0;
        m_in      = SW'($urandom);
        m_prev_in = SW'($urandom);
        s_in      = SW'($urandom);
        for (int i = 0; i < DIM; i++) begin
            v_star_in[i*DW +: DW]      = DW'($urandom);
            o_star_prev_in[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic do_accept();
        int n;
        drive_nxt();
        n = 0;
        @(negedge clk);
        while (!rdy_out && n < 20) begin @(negedge clk); n++; end
        chk("accept_rdy", rdy_out, 1);
        @(posedge clk); #1;
        take_nxt();
        scramble();
    endtask

    // Called #1 after the acceptance edge; consumes the CALC cycle and all beats.
    task automatic do_stream(input bit chain, input int bp, input int abort_at);
        logic [LANES*DW-1:0] ve, oe;
        logic [63:0]         t;
        bit                  se, s1;
        int                  b, cyc, i;
        @(negedge clk);
        chk("calc_vld", vld_out, 0);
        chk("calc_rdy", rdy_out, 0);
        @(posedge clk); #1;
        b = 0;
        cyc = 0;
        while (b < NB && cyc < 400) begin
            cyc++;
            rdy_in = ($urandom_range(0, 99) >= bp);
            if (chain && b == NB - 1 && rdy_in) drive_nxt();
            ve = '0; oe = '0; se = 1'b0;
            for (int j = 0; j < LANES; j++) begin
                i = b * LANES + j;
                if (i < DIM) begin
                    t = scale_ref(cur_v[i], cur_ev, s1); ve[j*DW +: DW] = t[DW-1:0]; se |= s1;
                    t = scale_ref(cur_o[i], cur_eo, s1); oe[j*DW +: DW] = t[DW-1:0]; se |= s1;
                end
            end
            @(negedge clk);
            chk("beat_vld", vld_out, 1);
            chk("beat_idx", beat_idx_out, b);
            chk("beat_last", last_out, (b == NB - 1));
            chk("beat_v", exp_v_out, ve);
            chk("beat_o", exp_o_out, oe);
            chk("beat_sat", sat_out, se);
            chk("beat_rdy", rdy_out, (b == NB - 1) && rdy_in);
            if (b == 0) begin
                cap_v1 = exp_v_out[DW +: DW];
                cap_v2 = exp_v_out[2*DW +: DW];
                cap_o1 = exp_o_out[DW +: DW];
                cap_sat0 = sat_out;
            end
            if (b == 1) cap_sat1 = sat_out;
            if (vld_out && rdy_in) begin
                beats_seen++;
                if (last_out) last_beat_seen = int'(beat_idx_out);
            end
            if (b == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_vld", vld_out, 0);
                chk("abort_v", exp_v_out, 0);
                chk("abort_rdy", rdy_out, 0);
                return;
            end
            @(posedge clk); #1;
            if (rdy_in) b++;
        end
        chk("stream_done", b, NB);
        if (chain) begin take_nxt(); scramble(); end
    endtask

    initial begin
        rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b0;
        m_in = '0; m_prev_in = '0; s_in = '0;
        v_star_in = '0; o_star_prev_in = '0;
        beats_seen = 0; last_beat_seen = -1;

        // Reset state
        @(negedge clk);
        chk("rst_vld", vld_out, 0);
        chk("rst_rdy", rdy_out, 0);
        chk("rst_v", exp_v_out, 0);
        chk("rst_o", exp_o_out, 0);
        chk("rst_beat", beat_idx_out, 0);
        chk("rst_last", last_out, 0);
        chk("rst_sat", sat_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release_rdy", rdy_out, 1);
        @(posedge clk); #1;

        // Identity
        clear_nxt(); nxt_v[1] = 32768; nxt_o[1] = 32768;
        do_accept(); do_stream(1'b0, 0, -1);
        chk("id_v1", cap_v1, 32768);
        chk("id_o1", cap_o1, 32768);
        chk("id_sat", cap_sat0, 0);
        chk("id_beats", beats_seen, 9);
        chk("id_last_beat", last_beat_seen, 8);

        // Rounding
        clear_nxt(); nxt_s = -16; nxt_v[1] = 32768;
        do_accept(); do_stream(1'b0, 0, -1);
        chk("round_s16", cap_v1, 16384);
        clear_nxt(); nxt_s = -5; nxt_v[1] = 32768;
        do_accept(); do_stream(1'b0, 0, -1);
        chk("round_s5", cap_v1, 32768);
        clear_nxt(); nxt_s = -6; nxt_v[1] = 32768;
        do_accept(); do_stream(1'b0, 0, -1);
        chk("round_s6", cap_v1, 16384);

        // Saturation
        clear_nxt(); nxt_mp = 16; nxt_o[1] = 40000000;
        do_accept(); do_stream(1'b0, 0, -1);
        chk("sat_o1", cap_o1, 67108863);
        chk("sat_beat0", cap_sat0, 1);
        chk("sat_beat1", cap_sat1, 0);

        // Deep shift
        clear_nxt(); nxt_m = 255; nxt_s = -256; nxt_v[1] = 50; nxt_v[2] = -1;
        do_accept(); do_stream(1'b0, 0, -1);
        chk("deep_pos", cap_v1, 0);
        chk("deep_neg", cap_v2, {DW{1'b1}});

        // Random back-to-back transactions under backpressure
        gen_rand();
        do_accept();
        for (int k = 0; k < 256; k++) begin
            if (k < 255) gen_rand();
            do_stream(k < 255, 30, -1);
        end

        // Reset during beat 3
        gen_rand();
        do_accept(); do_stream(1'b0, 0, 3);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", rdy_out, 1);
        chk("post_rst_vld", vld_out, 0);
        @(posedge clk); #1;
        gen_rand();
        do_accept(); do_stream(1'b0, 20, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/expmul_stream.md
# expmul_stream

Parametrised successor to the single-shot exp-multiply stage of the FlashAttention online-softmax datapath. Accepts a full score-update transaction (running max `m`, previous max `m_prev`, new score `s`, previous output accumulator `o*` and value vector `v*`) in one handshake. Computes the two base-2 exponents once: `e_v ≈ (s−m)·log2e` and `e_o ≈ (m_prev−m)·log2e`. Streams the rescaled vectors `v*·2^e_v` and `o*·2^e_o` to the accumulator in beats of `LANES` elements, with saturation reporting and full downstream backpressure.

## Interface
Parameters:
- `DIM`, 65: elements per vector (embedding dim + 1).
- `LANES`, 8: elements per output beat; `NB = ceil(DIM/LANES)` beats per vector.
- `DW`, 27: element width, signed Q9.17.
- `SW`, 9: scalar width, signed Q4.4 (`m`, `m_prev`, `s`).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `vld_in` in 1: upstream transaction valid.
- `rdy_out` out 1: block ready to accept a transaction.
- `m_in`, `m_prev_in`, `s_in` in SW each: signed Q4.4 scalars.
- `o_star_prev_in` in DIM×DW: previous output accumulator vector.
- `v_star_in` in DIM×DW: value vector.
- `vld_out` out 1: output beat valid.
- `rdy_in` in 1: downstream ready.
- `exp_v_out` out LANES×DW: rescaled v lanes of the current beat.
- `exp_o_out` out LANES×DW: rescaled o lanes of the current beat.
- `beat_idx_out` out clog2(NB): index of the current beat.
- `last_out` out 1: current beat is beat NB−1.
- `sat_out` out 1: at least one lane of the current beat saturated.

## Operation
- FSM states: IDLE, CALC, STREAM.
- IDLE:
  - `rdy_out=1`.
  - On `vld_in && rdy_out`, latch all inputs, then go to CALC.
- CALC, one cycle:
  - `d_v = s−m`, `d_o = m_prev−m`, both sign-extended to SW+1.
  - `t = 23·d`, i.e. `d + d/2 − d/16` in Q.8, computed exactly with no intermediate truncation.
  - `e = sign(t)·((|t| + 128) >> 8)`: round half away from zero. Range ±46.
  - Register `e_v` and `e_o`, set `beat = 0`, go to STREAM.
- STREAM:
  - `vld_out=1`.
  - Lane `j` of beat `b` is element `i = b·LANES + j`.
  - Lanes with `i ≥ DIM` output 0 and never flag saturation.
  - `e < 0`: arithmetic right shift by `min(−e, DW−1)`, floor toward −∞.
  - `e > 0`: left shift; if the result overflows signed DW, saturate to `+2^(DW−1)−1` / `−2^(DW−1)` and set `sat_out` for that beat.
  - `e = 0`: pass-through.
  - On `vld_out && rdy_in`: if `beat < NB−1`, increment `beat`; if last beat, go to IDLE.
- Back-to-back transfer:
  - `rdy_out = IDLE || (STREAM && last_out && rdy_in)`.
  - When a new transaction is accepted on the last-beat handshake, go directly to CALC.
- Outputs are a function of registered state only; there is no combinational path from `vld_in` to `vld_out`.
- `rdy_out` depends combinationally on `rdy_in`; this is the only combinational path through the block.

## Timing
- Reset, asynchronous and active-high:
  - state IDLE, `beat = 0`, `e_v = e_o = 0`, latched vectors 0.
  - `vld_out = 0`, `rdy_out = 0` while `rst = 1`.
  - `exp_v_out`, `exp_o_out`, `beat_idx_out`, `last_out`, `sat_out` all 0.
  - `rdy_out = 1` in the first cycle after deassertion.
- Latency:
  - Acceptance edge E0; CALC during the following cycle; `vld_out` high after E1.
  - Beat 0 is visible one cycle after acceptance.
- Throughput: `NB+1` cycles per transaction with `rdy_in` held high.
- Backpressure:
  - While `vld_out && !rdy_in`, all outputs hold stable.
  - `vld_out` never drops without a handshake.
- Inputs are sampled only at the acceptance edge. Changes afterwards do not affect the transaction in flight.
- Reset mid-STREAM aborts the transaction. No further beats of it are emitted.

## Test plan
- Identity: `m = m_prev = s = 0`, `v[1] = o[1] = 32768` → every beat is a pass-through, `exp_v_out[1] = 32768`, `sat_out = 0`, `NB = 9` beats, `last_out` on beat 8.
- Rounding, `m = 0`:
  - `s = −16`: `t = −368` → `e_v = −1`, 32768 → 16384.
  - `s = −5`: `e_v = 0`, 32768 unchanged.
  - `s = −6`: `t = −138` → `e_v = −1`, 32768 → 16384.
- Saturation: `m = 0`, `m_prev = 16`, `o[1] = 40000000` → `e_o = +1`, `exp_o_out[1] = 67108863`, `sat_out = 1` on beat 0 only.
- Deep shift: `s − m = −511` → `e = −46` → shift clamped to 26; `v = 50` → 0, `v = −1` → −1.
- Random backpressure plus back-to-back transactions:
  - Outputs stable under `rdy_in = 0`.
  - Next vector accepted on the last-beat handshake.
  - Scoreboard matches a real-valued model for 256 random `(m ≥ max(m_prev, s))` triples.
- Reset asserted during beat 3 → `vld_out = 0` immediately; `rdy_out = 1` one cycle after release; the next transaction streams from beat 0.
